// File: rtl/pl_ram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port block RAM, with a bounded burst lock for port B.
// Optional statistics counters are built when PL_RAM_ARB_STATS_EN is defined.
module pl_ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_wstrb,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH/8-1:0] b_wstrb,
  input  logic                    b_lock,
  output logic                    a_gnt,
  output logic                    b_gnt,
  output logic                    a_rvalid,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
`ifdef PL_RAM_ARB_STATS_EN
  output logic [31:0]             stat_conflicts,
  output logic [15:0]             stat_lock_exp,
`endif
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  typedef enum logic {ST_RR, ST_LOCK_B} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic               last_b;
  logic               gnt_any;

  logic               we_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [STRB_W-1:0]  strb_p0;

  logic               vld_p1, port_p1;
  logic               vld_p2, port_p2;

  // Stage p0: arbitration and command select
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    if (state == ST_LOCK_B && b_req && b_lock && lock_cnt < LOCK_MAX) begin
      b_gnt        = 1'b1;
      lock_cnt_nxt = lock_cnt + CNT_W'(1);
    end else begin
      // Tie goes to the port not granted last; after an expired burst that is A.
      state_nxt    = ST_RR;
      lock_cnt_nxt = '0;
      if (a_req && b_req) begin
        a_gnt = last_b;
        b_gnt = ~last_b;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
      if (b_gnt && b_lock) begin
        state_nxt    = ST_LOCK_B;
        lock_cnt_nxt = CNT_W'(1);
      end
    end
  end

  assign gnt_any  = a_gnt | b_gnt;
  assign we_p0    = b_gnt ? b_we    : a_we;
  assign addr_p0  = b_gnt ? b_addr  : a_addr;
  assign wdata_p0 = b_gnt ? b_wdata : a_wdata;
  assign strb_p0  = b_gnt ? b_wstrb : a_wstrb;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= ST_RR;
      lock_cnt <= '0;
      last_b   <= 1'b1;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (gnt_any) last_b <= b_gnt;
    end
  end

  // Stage p1: registered RAM command and read tag
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vld_p1    <= 1'b0;
      port_p1   <= 1'b0;
    end else begin
      ram_en <= gnt_any;
      ram_we <= '0;
      vld_p1 <= 1'b0;
      if (gnt_any) begin
        ram_addr  <= addr_p0;
        ram_wdata <= wdata_p0;
        ram_we    <= we_p0 ? strb_p0 : '0;
        vld_p1    <= ~we_p0;
        port_p1   <= b_gnt;
      end
    end
  end

  // Stage p2: read data returns from the RAM, routed by tag
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vld_p2  <= 1'b0;
      port_p2 <= 1'b0;
    end else begin
      vld_p2  <= vld_p1;
      port_p2 <= port_p1;
    end
  end

  assign a_rvalid = vld_p2 & ~port_p2;
  assign b_rvalid = vld_p2 &  port_p2;
  assign a_rdata  = ram_rdata;
  assign b_rdata  = ram_rdata;

`ifdef PL_RAM_ARB_STATS_EN
  logic lock_expire;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign lock_expire = (state == ST_LOCK_B) && (lock_cnt >= LOCK_MAX);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stat_conflicts <= '0;
      stat_lock_exp  <= '0;
    end else begin
      if (a_req && b_req) stat_conflicts <= sat_inc32(stat_conflicts);
      if (lock_expire)    stat_lock_exp  <= sat_inc16(stat_lock_exp);
    end
  end
`endif

endmodule

// File: tb/tb_pl_ram_arbiter.sv
// Randomized bench for pl_ram_arbiter: a behavioural RAM, a shadow memory and a grant-rule model.
// Statistics checks are compiled in when PL_RAM_ARB_STATS_EN is defined.
module tb_pl_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int ML = 16;

  logic ACLK = 1'b0;
  logic ARESET;
  logic a_req, a_we, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [SW-1:0] a_wstrb, b_wstrb;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic ram_en;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef PL_RAM_ARB_STATS_EN
  logic [31:0] stat_conflicts;
  logic [15:0] stat_lock_exp;
`endif

  always #5 ACLK = ~ACLK;

  pl_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_lock(b_lock), .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef PL_RAM_ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_lock_exp(stat_lock_exp),
`endif
    .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM, one cycle read latency
  logic [DW-1:0] mem [1<<AW];
  always @(posedge ACLK) begin
    if (ram_en) begin
      if (ram_we == '0) ram_rdata <= mem[ram_addr];
      else for (int i = 0; i < SW; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [DW-1:0] shadow [1<<AW];
  bit last_b = 1'b1;
  bit in_burst = 1'b0;
  int burst = 0;
  bit rv_a[4], rv_b[4];
  logic [DW-1:0] rd_a[4], rd_b[4];
  longint conflicts = 0;
  longint lock_exp = 0;
  logic [DW-1:0] last_a_data;
  bit g_a, g_b, d_gb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic arm_a(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [SW-1:0] s);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; a_wstrb = s;
  endtask

  task automatic arm_b(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [SW-1:0] s);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; b_wstrb = s;
  endtask

  // An accepted access takes effect in program order; reads see all earlier writes.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
    int slot;
    slot = (cyc + 2) % 4;
    if (we) begin
      for (int i = 0; i < SW; i++) if (s[i]) shadow[addr][8*i +: 8] = d[8*i +: 8];
    end else if (port) begin
      rv_b[slot] = 1'b1; rd_b[slot] = shadow[addr];
    end else begin
      rv_a[slot] = 1'b1; rd_a[slot] = shadow[addr];
    end
    last_b = port;
  endtask

  task automatic check_cycle();
    bit exp_a, exp_b;
    int s;
    exp_a = 1'b0; exp_b = 1'b0;
    if (in_burst && b_req && b_lock && burst < ML) exp_b = 1'b1;
    else begin
      if (in_burst && burst >= ML) lock_exp++;
      in_burst = 1'b0; burst = 0;
      if (a_req && b_req) begin exp_a = last_b; exp_b = !last_b; end
      else begin exp_a = a_req; exp_b = b_req; end
    end
    if (a_req && b_req) conflicts++;
    check("a_gnt", 64'(a_gnt), 64'(exp_a));
    check("b_gnt", 64'(b_gnt), 64'(exp_b));
    d_gb = b_gnt;
    s = cyc % 4;
    check("a_rvalid", 64'(a_rvalid), 64'(rv_a[s]));
    check("b_rvalid", 64'(b_rvalid), 64'(rv_b[s]));
    if (rv_a[s]) check("a_rdata", 64'(a_rdata), 64'(rd_a[s]));
    if (rv_b[s]) check("b_rdata", 64'(b_rdata), 64'(rd_b[s]));
    if (a_rvalid) last_a_data = a_rdata;
    rv_a[s] = 1'b0; rv_b[s] = 1'b0;
    if (exp_a) do_access(1'b0, a_we, a_addr, a_wdata, a_wstrb);
    if (exp_b) begin
      do_access(1'b1, b_we, b_addr, b_wdata, b_wstrb);
      if (in_burst) burst++;
      else if (b_lock) begin in_burst = 1'b1; burst = 1; end
    end
    g_a = exp_a; g_b = exp_b;
  endtask

  task automatic tick();
    @(negedge ACLK);
    check_cycle();
    @(posedge ACLK); #1;
    cyc++;
    if (g_a) a_req = 1'b0;
    if (g_b) b_req = 1'b0;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((a_req || b_req) && n < max) begin tick(); n++; end
    if (a_req || b_req) begin
      check("grant_timeout", 64'(a_req | b_req), 64'(0));
      a_req = 1'b0; b_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    ARESET = 1'b1;
    #1;
    check("rst_ram_en", 64'(ram_en), 64'(0));
    check("rst_ram_we", 64'(ram_we), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_wdata", 64'(ram_wdata), 64'(0));
    check("rst_a_rvalid", 64'(a_rvalid), 64'(0));
    check("rst_b_rvalid", 64'(b_rvalid), 64'(0));
`ifdef PL_RAM_ARB_STATS_EN
    check("rst_stat_conflicts", 64'(stat_conflicts), 64'(0));
    check("rst_stat_lock_exp", 64'(stat_lock_exp), 64'(0));
`endif
    for (int i = 0; i < 4; i++) begin rv_a[i] = 1'b0; rv_b[i] = 1'b0; end
    in_burst = 1'b0; burst = 0; last_b = 1'b1; conflicts = 0; lock_exp = 0;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, max_run;
    ARESET = 1'b0; a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0;
    a_wdata = '0; b_wdata = '0; a_wstrb = '0; b_wstrb = '0;
    #2;
    do_reset();

    // Fill the low words so every later read has a defined expectation
    for (int i = 0; i < 16; i++) begin arm_a(1'b1, AW'(i), $urandom, '1); run_until_idle(8); end

    // A-only writes then reads
    for (int i = 0; i < 4; i++) begin arm_a(1'b1, AW'(i), DW'(i + 1), '1); run_until_idle(8); end
    for (int i = 0; i < 4; i++) begin arm_a(1'b0, AW'(i), '0, '0); run_until_idle(8); end
    drain();
    check("a_only_last_read", 64'(last_a_data), 64'(32'h4));

    // Byte strobes, including an all-zero strobe write that must change nothing
    arm_a(1'b1, AW'(5), 32'hAABBCCDD, 4'hF); run_until_idle(8);
    arm_a(1'b1, AW'(5), 32'h11223344, 4'h5); run_until_idle(8);
    arm_a(1'b1, AW'(5), 32'hFFFFFFFF, 4'h0); run_until_idle(8);
    arm_a(1'b0, AW'(5), '0, '0); run_until_idle(8);
    drain();
    check("strobe_merge", 64'(last_a_data), 64'(32'hAA22CC44));

    // Interleaved reads: a B access first so A wins the following tie
    arm_b(1'b1, AW'(7), $urandom, '1); run_until_idle(8);
    arm_a(1'b0, AW'(0), '0, '0); arm_b(1'b0, AW'(1), '0, '0); run_until_idle(8);
    drain();

    // Constant contention without lock
    do_reset();
    for (int c = 0; c < 100; c++) begin
      if (!a_req) arm_a(1'b0, AW'($urandom_range(15)), '0, '0);
      if (!b_req) arm_b(1'b0, AW'($urandom_range(15)), '0, '0);
      tick();
    end
`ifdef PL_RAM_ARB_STATS_EN
    check("stat_conflicts_100", 64'(stat_conflicts), 64'(100));
`endif
    a_req = 1'b0; b_req = 1'b0;
    drain();

    // Lock limit: B bursts are capped at ML grants, then A gets one
    b_lock = 1'b1; run = 0; max_run = 0;
    for (int c = 0; c < 60; c++) begin
      if (!a_req) arm_a(1'b0, AW'($urandom_range(15)), '0, '0);
      if (!b_req) arm_b(1'b0, AW'($urandom_range(15)), '0, '0);
      tick();
      if (d_gb) run++;
      else begin if (run > max_run) max_run = run; run = 0; end
    end
    check("lock_max_run", 64'(max_run), 64'(ML));
`ifdef PL_RAM_ARB_STATS_EN
    check("stat_lock_exp", 64'(stat_lock_exp), 64'(lock_exp));
`endif
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    drain();

    // Reset one cycle after a read grant: the read must vanish
    arm_a(1'b0, AW'(3), '0, '0); tick();
    do_reset();
    drain();
    arm_a(1'b0, AW'(2), '0, '0); arm_b(1'b0, AW'(4), '0, '0);
    tick();
    check("first_tie_after_reset", 64'(g_a), 64'(1));
    run_until_idle(8);
    drain();

    // Randomized traffic with withdrawals and lock toggling
    for (int c = 0; c < 3000; c++) begin
      if (!a_req && $urandom_range(3) != 0)
        arm_a(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, SW'($urandom));
      else if (a_req && $urandom_range(15) == 0) a_req = 1'b0;
      if (!b_req && $urandom_range(3) != 0)
        arm_b(1'($urandom_range(1)), AW'($urandom_range(15)), $urandom, SW'($urandom));
      else if (b_req && $urandom_range(15) == 0) b_req = 1'b0;
      if ($urandom_range(7) == 0) b_lock = ~b_lock;
      tick();
    end
    a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    drain();
`ifdef PL_RAM_ARB_STATS_EN
    check("stat_conflicts_end", 64'(stat_conflicts), 64'(conflicts));
    check("stat_lock_exp_end", 64'(stat_lock_exp), 64'(lock_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
